// File: rtl/axis_pulse_pkg.sv
// Shared state encoding, framing constants and helpers for the pulse-key sequencer.
package axis_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HIGH  = 2'd2,
    ST_GUARD = 2'd3
  } pulse_state_t;

  // One UART frame of misc data: 54 bits at 63 beats per bit; smallest safe cfg_guard.
  localparam int unsigned UART_FRAME_BEATS = 54 * 63;
  localparam int unsigned REFLECT_BEATS    = 40;

  function automatic logic [15:0] sat_add16(input logic [15:0] value, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, value} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/axis_pulse_timer.sv
// Beat-gated period counter: counts 0..period-1 on beats and ticks on the wrap beat.
import axis_pulse_pkg::*;

module axis_pulse_timer #(
  parameter int CNTR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  run,
  input  logic                  beat,
  input  logic [CNTR_WIDTH-1:0] cfg_period,
  output logic                  tick
);

  localparam logic [CNTR_WIDTH-1:0] ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

  logic [CNTR_WIDTH-1:0] count;
  logic [CNTR_WIDTH-1:0] period_q;
  logic                  at_wrap;

  assign at_wrap = (period_q != '0) && (count == period_q - ONE);
  assign tick    = run & beat & at_wrap;

  // A zero period keeps reloading so a later non-zero value takes effect at once.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      count    <= '0;
      period_q <= '0;
    end else if (!run || (period_q == '0)) begin
      count    <= '0;
      period_q <= cfg_period;
    end else if (beat) begin
      if (at_wrap) begin
        count    <= '0;
        period_q <= cfg_period;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/axis_pulse_sequencer.sv
// Inserts the pulse-key bit into the stream MSB, merging periodic and software
// pulse requests and enforcing a start-to-start lockout between pulses.
import axis_pulse_pkg::*;

module axis_pulse_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 40,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_enable,
  input  logic [CNTR_WIDTH-1:0]       cfg_period,
  input  logic [CNTR_WIDTH-1:0]       cfg_width,
  input  logic [CNTR_WIDTH-1:0]       cfg_guard,
  input  logic                        sw_trig,
  output logic [31:0]                 pulse_count,
  output logic [15:0]                 dropped_count,
  output logic                        busy,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid
);

  localparam logic [CNTR_WIDTH-1:0] ONE   = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNTR_WIDTH:0]   ONE_X = {{CNTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [CNTR_WIDTH:0]   TWO_X = {{(CNTR_WIDTH-1){1'b0}}, 2'b10};

  pulse_state_t          state, state_next;
  logic                  key_reg, key_next;
  logic                  pending, pending_next;
  logic [CNTR_WIDTH-1:0] lock_cnt, lock_cnt_next;
  logic [CNTR_WIDTH-1:0] width_eff, width_eff_next;
  logic [CNTR_WIDTH:0]   guard_eff, guard_eff_next;
  logic [31:0]           pulse_count_next;
  logic [15:0]           dropped_count_next;

  logic                  beat;
  logic                  tick;
  logic                  request;
  logic                  consume;
  logic                  drop_tick;
  logic                  drop_sw;
  logic [CNTR_WIDTH-1:0] lock_inc;
  logic [CNTR_WIDTH-1:0] width_sel;
  logic [CNTR_WIDTH:0]   width_plus;
  logic [CNTR_WIDTH:0]   guard_sel;
  logic [CNTR_WIDTH:0]   guard_last;
  logic                  unused_tdata_msb;

  assign s_axis_tready    = m_axis_tready;
  assign m_axis_tvalid    = s_axis_tvalid;
  assign m_axis_tdata     = {key_reg, s_axis_tdata[AXIS_TDATA_WIDTH-2:0]};
  assign unused_tdata_msb = s_axis_tdata[AXIS_TDATA_WIDTH-1];

  assign beat    = s_axis_tvalid & m_axis_tready;
  assign request = tick | pending;
  assign busy    = (state == ST_HIGH) || (state == ST_GUARD);

  // Guard is one bit wider so width+1 cannot wrap for an all-ones width.
  assign lock_inc   = lock_cnt + ONE;
  assign width_sel  = (cfg_width == '0) ? ONE : cfg_width;
  assign width_plus = {1'b0, width_sel} + ONE_X;
  assign guard_sel  = ({1'b0, cfg_guard} > width_plus) ? {1'b0, cfg_guard} : width_plus;
  assign guard_last = guard_eff - ONE_X;

  axis_pulse_timer #(
    .CNTR_WIDTH (CNTR_WIDTH)
  ) u_timer (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .run        (state != ST_IDLE),
    .beat       (beat),
    .cfg_period (cfg_period),
    .tick       (tick)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      key_reg       <= 1'b0;
      pending       <= 1'b0;
      lock_cnt      <= '0;
      width_eff     <= ONE;
      guard_eff     <= TWO_X;
      pulse_count   <= '0;
      dropped_count <= '0;
    end else begin
      state         <= state_next;
      key_reg       <= key_next;
      pending       <= pending_next;
      lock_cnt      <= lock_cnt_next;
      width_eff     <= width_eff_next;
      guard_eff     <= guard_eff_next;
      pulse_count   <= pulse_count_next;
      dropped_count <= dropped_count_next;
    end
  end

  // The lockout counter holds beats since the accepted request; leaving on
  // guard_eff-1 makes the guard_eff-th beat after a request the next ARMED beat.
  always_comb begin
    state_next       = state;
    key_next         = key_reg;
    pending_next     = pending;
    lock_cnt_next    = lock_cnt;
    width_eff_next   = width_eff;
    guard_eff_next   = guard_eff;
    pulse_count_next = pulse_count;
    consume          = 1'b0;
    drop_tick        = 1'b0;
    drop_sw          = 1'b0;

    if ((state != ST_IDLE) && !cfg_enable) begin
      state_next   = ST_IDLE;
      key_next     = 1'b0;
      pending_next = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          key_next      = 1'b0;
          pending_next  = 1'b0;
          lock_cnt_next = '0;
          if (cfg_enable) begin
            state_next = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (beat && request) begin
            state_next       = ST_HIGH;
            key_next         = 1'b1;
            pulse_count_next = pulse_count + 32'd1;
            lock_cnt_next    = '0;
            width_eff_next   = width_sel;
            guard_eff_next   = guard_sel;
            consume          = 1'b1;
          end
        end
        ST_HIGH: begin
          if (beat) begin
            lock_cnt_next = lock_inc;
            drop_tick     = tick;
            if (lock_inc == width_eff) begin
              key_next   = 1'b0;
              state_next = ({1'b0, lock_inc} >= guard_last) ? ST_ARMED : ST_GUARD;
            end
          end
        end
        ST_GUARD: begin
          if (beat) begin
            lock_cnt_next = lock_inc;
            drop_tick     = tick;
            if ({1'b0, lock_inc} >= guard_last) begin
              state_next = ST_ARMED;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
          key_next   = 1'b0;
        end
      endcase

      // A trigger in the same clock as a consumed request re-arms the flag.
      if (state != ST_IDLE) begin
        if (consume) begin
          pending_next = 1'b0;
        end
        if (sw_trig) begin
          if (pending && !consume) begin
            drop_sw = 1'b1;
          end else begin
            pending_next = 1'b1;
          end
        end
      end
    end

    dropped_count_next = sat_add16(dropped_count, {1'b0, drop_tick} + {1'b0, drop_sw});
  end

endmodule

// File: tb/tb_axis_pulse_sequencer.sv
// Randomised bench for axis_pulse_sequencer against a beat-index model of the
// pulse rules (request spacing, key window, drop accounting).
module tb_axis_pulse_sequencer;

  localparam int DW = 40;
  localparam int CW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [CW-1:0] cfg_period = '0;
  logic [CW-1:0] cfg_width = '0;
  logic [CW-1:0] cfg_guard = '0;
  logic          sw_trig = 1'b0;
  logic [31:0]   pulse_count;
  logic [15:0]   dropped_count;
  logic          busy;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;

  int n_vec = 0;
  int n_err = 0;

  // Model state: beats are numbered from the first beat after arming.
  logic        m_running = 1'b0;
  logic        m_pending = 1'b0;
  logic        m_has = 1'b0;
  longint      m_beat_idx = 0;
  longint      m_last_r = 0;
  longint      m_w = 1;
  longint      m_g = 2;
  longint      m_period = 0;
  logic [31:0] m_pulses = '0;
  int          m_drop = 0;

  logic last_was_beat;
  logic last_beat_key;

  axis_pulse_sequencer #(
    .AXIS_TDATA_WIDTH (DW),
    .CNTR_WIDTH       (CW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_enable    (cfg_enable),
    .cfg_period    (cfg_period),
    .cfg_width     (cfg_width),
    .cfg_guard     (cfg_guard),
    .sw_trig       (sw_trig),
    .pulse_count   (pulse_count),
    .dropped_count (dropped_count),
    .busy          (busy),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid)
  );

  always #5 aclk = ~aclk;

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic drive_beat(input logic en, input logic sw, input logic tv, input logic tr);
    logic [63:0] rnd;
    logic        tick_now;
    logic        exp_key;
    logic        exp_busy;
    longint      b;
    rnd = {$urandom, $urandom};
    cfg_enable    = en;
    sw_trig       = sw;
    s_axis_tvalid = tv;
    m_axis_tready = tr;
    s_axis_tdata  = rnd[DW-1:0];
    last_was_beat = tv & tr;
    last_beat_key = m_axis_tdata[DW-1];
    @(posedge aclk);
    if (!aresetn) begin
      m_running = 1'b0;
      m_pending = 1'b0;
      m_has     = 1'b0;
      m_pulses  = '0;
      m_drop    = 0;
    end else if (!m_running) begin
      if (en) begin
        m_running  = 1'b1;
        m_beat_idx = 0;
        m_has      = 1'b0;
        m_pending  = 1'b0;
        m_period   = longint'({32'd0, cfg_period});
      end
    end else if (!en) begin
      m_running = 1'b0;
      m_pending = 1'b0;
    end else begin
      if (tv && tr) begin
        b = m_beat_idx;
        tick_now = 1'b0;
        if (m_period != 0) tick_now = (((b + 1) % m_period) == 0);
        if (m_has && (b < m_last_r + m_g)) begin
          if (tick_now && (m_drop < 65535)) m_drop++;
        end else if (tick_now || m_pending) begin
          m_last_r  = b;
          m_has     = 1'b1;
          m_w       = (cfg_width == '0) ? 1 : longint'({32'd0, cfg_width});
          m_g       = (longint'({32'd0, cfg_guard}) > m_w + 1) ? longint'({32'd0, cfg_guard}) : m_w + 1;
          m_pulses  = m_pulses + 32'd1;
          m_pending = 1'b0;
        end
        m_beat_idx++;
      end
      if (sw) begin
        if (m_pending) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          m_pending = 1'b1;
        end
      end
    end
    #1;
    exp_key  = m_running && m_has && (m_beat_idx <= m_last_r + m_w);
    exp_busy = m_running && m_has && (m_beat_idx < m_last_r + m_g);
    n_vec++;
    if (m_axis_tdata[DW-1] !== exp_key) begin
      n_err++;
      $display("[TB] FAIL key t=%0t got %b want %b", $time, m_axis_tdata[DW-1], exp_key);
    end
    n_vec++;
    if (busy !== exp_busy) begin
      n_err++;
      $display("[TB] FAIL busy t=%0t got %b want %b", $time, busy, exp_busy);
    end
    n_vec++;
    if (pulse_count !== m_pulses) begin
      n_err++;
      $display("[TB] FAIL pulse_count t=%0t got %0d want %0d", $time, pulse_count, m_pulses);
    end
    n_vec++;
    if (dropped_count !== m_drop[15:0]) begin
      n_err++;
      $display("[TB] FAIL dropped_count t=%0t got %0d want %0d", $time, dropped_count, m_drop);
    end
    n_vec++;
    if (m_axis_tdata[DW-2:0] !== s_axis_tdata[DW-2:0]) begin
      n_err++;
      $display("[TB] FAIL tdata t=%0t got %h want %h", $time, m_axis_tdata[DW-2:0], s_axis_tdata[DW-2:0]);
    end
    n_vec++;
    if ((m_axis_tvalid !== tv) || (s_axis_tready !== tr)) begin
      n_err++;
      $display("[TB] FAIL handshake t=%0t got v=%b r=%b want v=%b r=%b", $time, m_axis_tvalid, s_axis_tready, tv, tr);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_beat(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic arm();
    drive_beat(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    for (int i = 0; i < 3; i++) drive_beat(1'b1, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if ((pulse_count !== 32'd0) || (dropped_count !== 16'd0) || (busy !== 1'b0) || (m_axis_tdata[DW-1] !== 1'b0)) begin
      n_err++;
      $display("[TB] FAIL reset_state got p=%0d d=%0d busy=%b key=%b want all 0", pulse_count, dropped_count, busy, m_axis_tdata[DW-1]);
    end
    aresetn = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_periodic();
    logic [31:0] p0;
    int          d0;
    logic        want;
    p0 = m_pulses;
    d0 = m_drop;
    cfg_period = 100; cfg_width = 5; cfg_guard = 50;
    arm();
    for (int i = 0; i < 1005; i++) begin
      drive_beat(1'b1, 1'b0, 1'b1, 1'b1);
      want = ((i + 1) >= 100) && (((i + 1) % 100) < 5);
      n_vec++;
      if (m_axis_tdata[DW-1] !== want) begin
        n_err++;
        $display("[TB] FAIL periodic_key beat %0d got %b want %b", i + 1, m_axis_tdata[DW-1], want);
      end
    end
    n_vec++;
    if ((pulse_count !== p0 + 32'd10) || (dropped_count !== d0[15:0])) begin
      n_err++;
      $display("[TB] FAIL periodic_counts got p=%0d d=%0d want p=%0d d=%0d", pulse_count, dropped_count, p0 + 32'd10, d0);
    end
    idle_cycles(3);
  endtask

  task automatic test_guard_drop();
    logic [31:0] p0;
    int          d0;
    p0 = m_pulses;
    d0 = m_drop;
    cfg_period = 100; cfg_width = 5; cfg_guard = 150;
    arm();
    for (int i = 0; i < 500; i++) drive_beat(1'b1, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if ((pulse_count !== p0 + 32'd3) || (dropped_count !== d0[15:0] + 16'd2) || (m_axis_tdata[DW-1] !== 1'b1)) begin
      n_err++;
      $display("[TB] FAIL guard_drop got p=%0d d=%0d key=%b want p=%0d d=%0d key=1", pulse_count, dropped_count, m_axis_tdata[DW-1], p0 + 32'd3, d0 + 2);
    end
    idle_cycles(3);
  endtask

  task automatic test_sw_guard();
    int d0;
    d0 = m_drop;
    cfg_period = 0; cfg_width = 2; cfg_guard = 20;
    arm();
    for (int i = 0; i < 30; i++) begin
      drive_beat(1'b1, (i == 0) || (i == 5) || (i == 8), 1'b1, 1'b1);
      if ((i == 20) || (i == 21)) begin
        n_vec++;
        if (m_axis_tdata[DW-1] !== (i == 21)) begin
          n_err++;
          $display("[TB] FAIL sw_after_lockout beat %0d got %b want %b", i + 1, m_axis_tdata[DW-1], (i == 21));
        end
      end
    end
    n_vec++;
    if (dropped_count !== d0[15:0] + 16'd1) begin
      n_err++;
      $display("[TB] FAIL sw_guard_drop got %0d want %0d", dropped_count, d0 + 1);
    end
    idle_cycles(3);
  endtask

  task automatic test_coincide();
    logic [31:0] p0;
    int          d0;
    p0 = m_pulses;
    d0 = m_drop;
    cfg_period = 10; cfg_width = 1; cfg_guard = 0;
    arm();
    for (int i = 0; i < 12; i++) drive_beat(1'b1, (i == 8), 1'b1, 1'b1);
    n_vec++;
    if ((pulse_count !== p0 + 32'd1) || (dropped_count !== d0[15:0])) begin
      n_err++;
      $display("[TB] FAIL coincide got p=%0d d=%0d want p=%0d d=%0d", pulse_count, dropped_count, p0 + 32'd1, d0);
    end
    idle_cycles(3);
  endtask

  task automatic test_min_width();
    cfg_period = 1; cfg_width = 0; cfg_guard = 0;
    arm();
    for (int i = 0; i < 10; i++) begin
      drive_beat(1'b1, 1'b0, 1'b1, 1'b1);
      n_vec++;
      if (m_axis_tdata[DW-1] !== ((i % 2) == 0)) begin
        n_err++;
        $display("[TB] FAIL min_width_key beat %0d got %b want %b", i + 1, m_axis_tdata[DW-1], ((i % 2) == 0));
      end
    end
    idle_cycles(3);
  endtask

  task automatic test_stall();
    logic q_stall[$];
    logic q_free[$];
    logic want;
    int   budget;
    cfg_period = 7; cfg_width = 3; cfg_guard = 5;
    arm();
    budget = 0;
    while ((q_stall.size() < 120) && (budget < 2000)) begin
      drive_beat(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      if (last_was_beat) q_stall.push_back(last_beat_key);
      budget++;
    end
    n_vec++;
    if (q_stall.size() != 120) begin
      n_err++;
      $display("[TB] FAIL stall_budget got %0d beats want 120", q_stall.size());
    end
    idle_cycles(2);
    arm();
    for (int i = 0; i < 120; i++) begin
      drive_beat(1'b1, 1'b0, 1'b1, 1'b1);
      q_free.push_back(last_beat_key);
    end
    for (int k = 0; k < q_stall.size(); k++) begin
      want = (k >= 7) && ((k % 7) <= 2);
      n_vec++;
      if ((q_stall[k] !== want) || (q_free[k] !== want)) begin
        n_err++;
        $display("[TB] FAIL stall_pattern beat %0d got stalled=%b free=%b want %b", k, q_stall[k], q_free[k], want);
      end
    end
    for (int i = 0; i < 600; i++) begin
      if ((i % 150) == 0) begin
        idle_cycles(1);
        cfg_period = $urandom_range(0, 12);
        cfg_width  = $urandom_range(0, 4);
        cfg_guard  = $urandom_range(0, 10);
        arm();
      end
      drive_beat(1'b1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end
    idle_cycles(3);
  endtask

  task automatic test_disable();
    logic [31:0] p0;
    int          d0;
    cfg_period = 20; cfg_width = 10; cfg_guard = 15;
    arm();
    for (int i = 0; i < 23; i++) drive_beat(1'b1, 1'b0, 1'b1, 1'b1);
    p0 = m_pulses;
    d0 = m_drop;
    drive_beat(1'b0, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if ((m_axis_tdata[DW-1] !== 1'b0) || (pulse_count !== p0) || (dropped_count !== d0[15:0])) begin
      n_err++;
      $display("[TB] FAIL disable got key=%b p=%0d d=%0d want key=0 p=%0d d=%0d", m_axis_tdata[DW-1], pulse_count, dropped_count, p0, d0);
    end
    idle_cycles(2);
    arm();
    for (int i = 0; i < 20; i++) begin
      drive_beat(1'b1, 1'b0, 1'b1, 1'b1);
      if ((i == 18) || (i == 19)) begin
        n_vec++;
        if (m_axis_tdata[DW-1] !== (i == 19)) begin
          n_err++;
          $display("[TB] FAIL period_restart beat %0d got %b want %b", i + 1, m_axis_tdata[DW-1], (i == 19));
        end
      end
    end
    idle_cycles(3);
  endtask

  task automatic test_saturation();
    cfg_period = 1; cfg_width = 1; cfg_guard = 32'hFFFF_FFFF;
    arm();
    for (int i = 0; i < 33000; i++) drive_beat(1'b1, 1'b1, 1'b1, 1'b1);
    n_vec++;
    if (dropped_count !== 16'hFFFF) begin
      n_err++;
      $display("[TB] FAIL drop_saturation got %h want FFFF", dropped_count);
    end
    idle_cycles(3);
  endtask

  task automatic test_reset_guard();
    cfg_period = 0; cfg_width = 2; cfg_guard = 30;
    arm();
    drive_beat(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) drive_beat(1'b1, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if ((busy !== 1'b1) || (m_axis_tdata[DW-1] !== 1'b0)) begin
      n_err++;
      $display("[TB] FAIL in_guard got busy=%b key=%b want busy=1 key=0", busy, m_axis_tdata[DW-1]);
    end
    aresetn = 1'b0;
    drive_beat(1'b1, 1'b0, 1'b1, 1'b1);
    n_vec++;
    if ((pulse_count !== 32'd0) || (dropped_count !== 16'd0) || (busy !== 1'b0) || (m_axis_tdata[DW-1] !== 1'b0)) begin
      n_err++;
      $display("[TB] FAIL reset_in_guard got p=%0d d=%0d busy=%b key=%b want all 0", pulse_count, dropped_count, busy, m_axis_tdata[DW-1]);
    end
    aresetn = 1'b1;
    idle_cycles(2);
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_periodic();
    test_guard_drop();
    test_sw_guard();
    test_coincide();
    test_min_width();
    test_stall();
    test_disable();
    test_saturation();
    test_reset_guard();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
